// File: rtl/comparator_serial_msb_if.sv
// Handshake and result bundle between a serial bit source and comparator_serial_msb.
// The master side drives start and the bit pairs; the slave side returns ready, status and the result.
interface comparator_serial_msb_if;
    logic       start;
    logic       bit_valid;
    logic       a_bit;
    logic       b_bit;
    logic       bit_ready;
    logic       busy;
    logic       done;
    logic [2:0] y;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  bit_ready, busy, done, y
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output bit_ready, busy, done, y
    );
endinterface

// File: rtl/comparator_serial_msb.sv
// MSB-first bit-serial unsigned magnitude comparator, result code {gt,lt,eq}.
// Optional macro COMPARE_EARLY_DONE_EN: finish on the first differing bit pair.
module comparator_serial_msb #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    comparator_serial_msb_if.slave io_bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      r_result;
    logic [2:0]      w_result_next;
    logic [2:0]      r_y;
    logic [2:0]      w_y_next;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic [2:0]      w_beat_result;

    assign w_accept = io_bus.bit_valid && (r_state == S_SHIFT);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // The first differing pair decides; once decided the result is frozen.
    always_comb begin
        w_beat_result = r_result;
        if ((r_result == 3'b001) && (io_bus.a_bit != io_bus.b_bit))
            w_beat_result = io_bus.a_bit ? 3'b100 : 3'b010;
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;
        w_y_next      = r_y;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state_next  = S_SHIFT;
                    w_cnt_next    = '0;
                    w_result_next = 3'b001;
                    w_y_next      = 3'b000;
                end
            end
            S_SHIFT: begin
                if (w_accept) begin
                    w_cnt_next    = r_cnt + CW'(1);
                    w_result_next = w_beat_result;
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_y_next     = w_beat_result;
                    end
`ifdef COMPARE_EARLY_DONE_EN
                    else if (w_beat_result != 3'b001) begin
                        w_state_next = S_DONE;
                        w_y_next     = w_beat_result;
                    end
`endif
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= 3'b001;
            r_y      <= 3'b000;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_result <= w_result_next;
            r_y      <= w_y_next;
            r_ready  <= (w_state_next == S_SHIFT);
            r_busy   <= (w_state_next != S_IDLE);
            r_done   <= (w_state_next == S_DONE);
        end
    end

    assign io_bus.bit_ready = r_ready;
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.y         = r_y;
endmodule
